// File: rtl/ntsc_timing_ctrl.sv
// ntsc_timing_ctrl: pixel divider, h/v counters, line-type FSM and registered
// sync / burst / active-window decode for a 262-line progressive NTSC frame.
module ntsc_timing_ctrl #(
    parameter int CLK_DIV     = 4,
    parameter int H_TOTAL     = 794,
    parameter int H_SYNC      = 59,
    parameter int H_BACK      = 72,
    parameter int H_ACTIVE    = 600,
    parameter int H_EQ        = 29,
    parameter int H_BURST_OFF = 7,
    parameter int H_BURST_LEN = 31,
    parameter int V_TOTAL     = 262,
    parameter int V_ACTIVE    = 240
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    output logic       pix_en,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic       active_video,
    output logic       sync_n,
    output logic       burst,
    output logic       line_start,
    output logic       frame_start
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DLAST = DW'(CLK_DIV - 1);
    localparam logic [9:0] HLAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] HALF  = 10'(H_TOTAL / 2);
    localparam logic [9:0] HSY   = 10'(H_SYNC);
    localparam logic [9:0] HEQ   = 10'(H_EQ);
    localparam logic [9:0] HEQ2  = 10'(H_TOTAL / 2 + H_EQ);
    localparam logic [9:0] HBRD  = 10'(H_TOTAL / 2 - H_SYNC);
    localparam logic [9:0] HBRD2 = 10'(H_TOTAL - H_SYNC);
    localparam logic [9:0] BST   = 10'(H_SYNC + H_BURST_OFF);
    localparam logic [9:0] BEND  = 10'(H_SYNC + H_BURST_OFF + H_BURST_LEN);
    localparam logic [9:0] AST   = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] AEND  = 10'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [8:0] VLAST = 9'(V_TOTAL - 1);
    localparam logic [8:0] VBL   = 9'(V_TOTAL - V_ACTIVE);

    typedef enum logic [2:0] {PREEQ, VSYNC, POSTEQ, BLANK, ACTIVE} line_t;

    logic [DW-1:0] div_cnt;
    logic [9:0] hcnt, hn;
    logic [8:0] vcnt, vn;
    logic run, tick, hwrap, wide, eq, low, bu_d, av_d;
    line_t state, sn;

    // run=0 means no pixel issued yet: the first tick presents pixel (0,0) as a wrap
    always_comb begin
        tick  = div_cnt == DLAST;
        hwrap = !run || hcnt == HLAST;
        hn    = hwrap ? 10'd0 : hcnt + 10'd1;
        vn    = !run ? 9'd0 : hwrap ? (vcnt == VLAST ? 9'd0 : vcnt + 9'd1) : vcnt;
        sn    = !hwrap ? state : vn < 9'd3 ? PREEQ : vn < 9'd6 ? VSYNC :
                vn < 9'd9 ? POSTEQ : vn < VBL ? BLANK : ACTIVE;
        wide  = sn == BLANK || sn == ACTIVE;
        eq    = sn == PREEQ || sn == POSTEQ;
        low   = wide ? hn < HSY :
                eq   ? (hn < HEQ || (hn >= HALF && hn < HEQ2)) :
                       (hn < HBRD || (hn >= HALF && hn < HBRD2));
        bu_d  = wide && hn >= BST && hn < BEND;
        av_d  = sn == ACTIVE && hn >= AST && hn < AEND;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {div_cnt, hcnt, vcnt, run, pix_en, x, y, active_video, burst, line_start, frame_start} <= '0;
            sync_n <= 1'b1;
            state  <= PREEQ;
        end else if (!enable) begin
            {div_cnt, hcnt, vcnt, run, pix_en, x, y, active_video, burst, line_start, frame_start} <= '0;
            sync_n <= 1'b1;
            state  <= PREEQ;
        end else begin
            div_cnt     <= tick ? '0 : div_cnt + 1'b1;
            pix_en      <= tick;
            line_start  <= tick && hwrap;
            frame_start <= tick && hwrap && vn == 9'd0;
            if (tick) begin
                run          <= 1'b1;
                hcnt         <= hn;
                vcnt         <= vn;
                state        <= sn;
                sync_n       <= !low;
                burst        <= bu_d;
                active_video <= av_d;
                x            <= av_d ? hn - AST : 10'd0;
                y            <= sn == ACTIVE ? vn - VBL : 9'd0;
            end
        end
    end
endmodule

// File: tb/tb_ntsc_timing_ctrl.sv
// tb_ntsc_timing_ctrl: default-size DUT over its first lines plus a shrunk DUT over
// whole frames, both compared every clock against a time-based reference model.
module tb_ntsc_timing_ctrl;
    typedef struct packed {
        logic       pe, av, sn, bu, ls, fs;
        logic [9:0] x;
        logic [8:0] y;
    } exp_t;

    // CLK_DIV, H_TOTAL, H_SYNC, H_BACK, H_ACTIVE, H_EQ, H_BURST_OFF, H_BURST_LEN, V_TOTAL, V_ACTIVE
    int cfg0[10] = '{4, 794, 59, 72, 600, 29, 7, 31, 262, 240};
    int cfg1[10] = '{3, 100, 8, 10, 70, 4, 2, 5, 24, 12};

    logic clk = 0, rst_n = 0, en0 = 0, en1 = 0;
    logic       pe0, av0, sn0, bu0, ls0, fs0, pe1, av1, sn1, bu1, ls1, fs1;
    logic [9:0] x0, x1;
    logic [8:0] y0, y1;
    int k0 = 0, k1 = 0, n_cmp = 0, n_bad = 0, drop = 0;

    always #5 clk = ~clk;

    ntsc_timing_ctrl u0 (.clk(clk), .rst_n(rst_n), .enable(en0), .pix_en(pe0), .x(x0), .y(y0),
        .active_video(av0), .sync_n(sn0), .burst(bu0), .line_start(ls0), .frame_start(fs0));

    ntsc_timing_ctrl #(.CLK_DIV(3), .H_TOTAL(100), .H_SYNC(8), .H_BACK(10), .H_ACTIVE(70), .H_EQ(4),
        .H_BURST_OFF(2), .H_BURST_LEN(5), .V_TOTAL(24), .V_ACTIVE(12)) u1 (
        .clk(clk), .rst_n(rst_n), .enable(en1), .pix_en(pe1), .x(x1), .y(y1),
        .active_video(av1), .sync_n(sn1), .burst(bu1), .line_start(ls1), .frame_start(fs1));

    // k = enabled clk edges since the last clear; pixel p is issued on edge (p+1)*CLK_DIV
    function automatic exp_t model(input int c[10], input int k);
        exp_t e;
        int p, h, v, half, vb, hs0;
        logic low;
        e = '0;
        e.sn = 1'b1;
        if (k < c[0]) return e;
        p = k / c[0] - 1;
        h = p % c[1];
        v = (p / c[1]) % c[8];
        half = c[1] / 2;
        vb = c[8] - c[9];
        hs0 = c[2] + c[3];
        e.pe = (k % c[0]) == 0;
        e.ls = e.pe && h == 0;
        e.fs = e.ls && v == 0;
        if (v < 3 || (v >= 6 && v < 9)) low = h < c[5] || (h >= half && h < half + c[5]);
        else if (v < 6) low = h < half - c[2] || (h >= half && h < c[1] - c[2]);
        else begin
            low = h < c[2];
            e.bu = h >= c[2] + c[6] && h < c[2] + c[6] + c[7];
        end
        e.sn = !low;
        if (v >= vb) begin
            e.y = 9'(v - vb);
            if (h >= hs0 && h < hs0 + c[4]) begin
                e.av = 1'b1;
                e.x = 10'(h - hs0);
            end
        end
        return e;
    endfunction

    task automatic chk(input string tag, input exp_t got, input exp_t e);
        n_cmp++;
        assert (got === e) else begin
            n_bad++;
            $error("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, e);
        end
    endtask

    task automatic check_all();
        chk("dflt", {pe0, av0, sn0, bu0, ls0, fs0, x0, y0}, model(cfg0, k0));
        chk("small", {pe1, av1, sn1, bu1, ls1, fs1, x1, y1}, model(cfg1, k1));
    endtask

    // one clk: count enabled edges, check on the falling edge, then maybe toggle en1
    task automatic run(input int n, input bit rnd);
        for (int i = 0; i < n && n_bad < 40; i++) begin
            @(posedge clk);
            k0 = (!rst_n || !en0) ? 0 : k0 + 1;
            k1 = (!rst_n || !en1) ? 0 : k1 + 1;
            @(negedge clk);
            check_all();
            if (drop > 0) begin
                drop--;
                if (drop == 0) en1 = 1;
            end else if (rnd && $urandom_range(0, 2499) == 0) begin
                en1 = 0;
                drop = $urandom_range(1, 4);
            end
        end
    endtask

    initial begin
        run(3, 0);
        rst_n = 1;
        run(2, 0);
        en0 = 1;
        en1 = 1;
        run(12000, 1);
        run(21500, 1);
        en0 = 0;
        run($urandom_range(1, 5), 0);
        en0 = 1;
        run(1000, 1);
        @(posedge clk);
        k0 = en0 ? k0 + 1 : 0;
        k1 = en1 ? k1 + 1 : 0;
        #1 rst_n = 0;
        #1 k0 = 0;
        k1 = 0;
        chk("async_rst0", {pe0, av0, sn0, bu0, ls0, fs0, x0, y0}, model(cfg0, 0));
        chk("async_rst1", {pe1, av1, sn1, bu1, ls1, fs1, x1, y1}, model(cfg1, 0));
        run(3, 0);
        rst_n = 1;
        drop = 0;
        en1 = 1;
        run(8000, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
